// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//
// Shares one single-port synchronous memory between the instruction-fetch port
// and the load/store port of a core. Each cycle one of the two requesters wins.
// The winning command goes straight to the memory, and the read data comes back
// to that requester one cycle later. A starvation counter makes sure fetch still
// makes progress while a long load/store burst is running.
//
// Parameters
//   AW          byte-address width of both requester ports
//   DW          data width, with byte-enable width DW/8
//   RR_MODE     0 = load/store has fixed priority, 1 = round-robin on contention
//   MAX_STARVE  number of denied fetch cycles in a row before fetch is forced to win (>=1)
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-low reset
//   if_req/if_addr            fetch request and word-aligned byte address
//   if_gnt                    fetch accepted this cycle
//   if_rvalid/if_rdata        fetch read data, one cycle after if_gnt
//   ls_req/ls_we/ls_be        load/store request, store flag, store byte enables
//   ls_addr/ls_wdata          load/store byte address and store data
//   ls_gnt                    load/store accepted this cycle
//   ls_rvalid/ls_rdata        load read data, one cycle after a load grant
//   mem_en/mem_we/mem_be      memory strobe, write enable, byte enables
//   mem_addr/mem_wdata        memory word address and write data
//   mem_rdata                 memory read data, valid the cycle after a read strobe

module unified_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int RR_MODE    = 0,
  parameter int MAX_STARVE = 4
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,

  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [DW/8-1:0] ls_be,
  input  logic [AW-1:0]   ls_addr,
  input  logic [DW-1:0]   ls_wdata,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [DW-1:0]   ls_rdata,

  output logic            mem_en,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-3:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int BW = DW / 8;
  localparam int SW = $clog2(MAX_STARVE + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_LS
  } own_t;

  typedef enum logic {
    WIN_IF,
    WIN_LS
  } win_t;

  own_t          rd_own;
  win_t          last_winner;
  logic [SW-1:0] starve_cnt;

  logic contend;
  logic force_if;
  logic pick_if;

  // The core guarantees word alignment, so the two low address bits are dropped.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{if_addr[1:0], ls_addr[1:0]};

  // Choose the winner. When only one side requests, that side wins. On
  // contention, a saturated starvation counter overrides both priority schemes.
  always_comb begin
    contend  = if_req & ls_req;
    force_if = (starve_cnt == STARVE_MAX);
    pick_if  = if_req;
    if (contend) begin
      if (force_if) begin
        pick_if = 1'b1;
      end else if (RR_MODE != 0) begin
        pick_if = (last_winner == WIN_LS);
      end else begin
        pick_if = 1'b0;
      end
    end
  end

  // Gating with rst keeps every grant, and so every memory strobe, low while
  // reset is held.
  assign if_gnt = rst & if_req & pick_if;
  assign ls_gnt = rst & ls_req & ~pick_if;

  // Route the winning command to the memory. Reads always use full byte
  // enables. Idle cycles drive all zeros.
  always_comb begin
    mem_en    = if_gnt | ls_gnt;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ls_gnt) begin
      mem_we   = ls_we;
      mem_be   = ls_we ? ls_be : {BW{1'b1}};
      mem_addr = ls_addr[AW-1:2];
      if (ls_we) begin
        mem_wdata = ls_wdata;
      end
    end else if (if_gnt) begin
      mem_be   = {BW{1'b1}};
      mem_addr = if_addr[AW-1:2];
    end
  end

  // Arbitration state:
  // - rd_own records who owns the read data arriving next cycle.
  // - starve_cnt counts denied fetch cycles in a row. It saturates at MAX_STARVE.
  // - last_winner is the round-robin pointer. It only moves on granted cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_own      <= OWN_NONE;
      starve_cnt  <= '0;
      last_winner <= WIN_IF;
    end else begin
      if (if_gnt) begin
        rd_own <= OWN_IF;
      end else if (ls_gnt && !ls_we) begin
        rd_own <= OWN_LS;
      end else begin
        rd_own <= OWN_NONE;
      end

      if (!if_req || if_gnt) begin
        starve_cnt <= '0;
      end else if (starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + SW'(1);
      end

      if (if_gnt) begin
        last_winner <= WIN_IF;
      end else if (ls_gnt) begin
        last_winner <= WIN_LS;
      end
    end
  end

  // A read granted just before reset still has rd_own set during the reset
  // cycle. Gating with rst discards that read.
  assign if_rvalid = rst & (rd_own == OWN_IF);
  assign ls_rvalid = rst & (rd_own == OWN_LS);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign ls_rdata  = ls_rvalid ? mem_rdata : '0;

endmodule
